opb_register_simulink2ppc: RTL and testbench

OPB slave register carrying data from the fabric (Simulink user logic) to the PowerPC, in the opposite direction to the PPC-to-fabric software register.
- User logic presents a 32-bit word with a valid strobe; the block captures it and the PPC reads it over OPB.
- Status and update-count words let software detect fresh data and missed updates.
- Single clock domain: user logic runs on OPB_Clk.

---
 rtl/opb_sw_reg_pkg.sv | 18 +
 rtl/opb_slave_ack.sv | 56 +++++
 rtl/opb_register_simulink2ppc.sv | 108 ++++++++++
 tb/tb_opb_register_simulink2ppc.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/opb_sw_reg_pkg.sv
// Shared definitions for the OPB software-register slaves: register offsets,
// STATUS bit positions and the bus acknowledge FSM states.
package opb_sw_reg_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int STAT_NEW_BIT = 0;
  localparam int STAT_OVR_BIT = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT
  } bus_state_e;

endpackage

// File: rtl/opb_slave_ack.sv
// OPB address decode plus IDLE/ACK/WAIT handshake: one single-cycle ack per
// select assertion, with read/write strobes on the cycle that enters ACK.
module opb_slave_ack
  import opb_sw_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0100_0400,
  parameter logic [31:0] C_HIGHADDR = 32'h0100_04FF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_abus,
  input  logic        i_rnw,
  input  logic        i_select,
  output logic        o_ack,
  output logic [1:0]  o_offset,
  output logic        o_rd_strobe,
  output logic        o_wr_strobe
);

  bus_state_e  r_state;
  bus_state_e  w_next;
  logic        w_hit;
  logic [31:0] w_rel;
  logic        w_unused_rel;

  assign w_hit        = i_select && (i_abus >= C_BASEADDR) && (i_abus <= C_HIGHADDR);
  assign w_rel        = i_abus - C_BASEADDR;
  assign o_offset     = w_rel[3:2];
  assign w_unused_rel = ^{w_rel[31:4], w_rel[1:0]};
  assign o_ack        = (r_state == ACK);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Strobes fire only on the IDLE->ACK transition so each select yields one access.
  always_comb begin
    w_next      = r_state;
    o_rd_strobe = 1'b0;
    o_wr_strobe = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_next      = ACK;
          o_rd_strobe = i_rnw;
          o_wr_strobe = !i_rnw;
        end
      end
      ACK:  w_next = WAIT;
      WAIT: if (!i_select) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// Fabric-to-PPC OPB register: captures a user word on a valid strobe and
// exposes DATA, STATUS (new/overrun) and an update counter to software.
module opb_register_simulink2ppc
  import opb_sw_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0400,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_04FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  input  logic [31:0] user_data_in,
  input  logic        user_data_valid
);

  logic [31:0] r_data;
  logic        r_new;
  logic        r_ovr;
  logic [31:0] r_cnt;
  logic [31:0] r_dbus;

  logic        w_ack;
  logic [1:0]  w_offset;
  logic        w_rd;
  logic        w_wr;
  logic        w_rd_data;
  logic        w_ovr_clr;
  logic [31:0] w_rd_word;
  logic        w_unused;

  opb_slave_ack #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_ack (
    .i_clk       (OPB_Clk),
    .i_rst       (OPB_Rst),
    .i_abus      (OPB_ABus),
    .i_rnw       (OPB_RNW),
    .i_select    (OPB_select),
    .o_ack       (w_ack),
    .o_offset    (w_offset),
    .o_rd_strobe (w_rd),
    .o_wr_strobe (w_wr)
  );

  // OPB_DBus[31] and OPB_BE[3] are the least significant bit and byte.
  assign w_rd_data = w_rd && (w_offset == OFF_DATA);
  assign w_ovr_clr = w_wr && (w_offset == OFF_STATUS) && OPB_BE[3] && OPB_DBus[31];

  always_comb begin
    w_rd_word = '0;
    case (w_offset)
      OFF_DATA:   w_rd_word = r_data;
      OFF_STATUS: begin
        w_rd_word[STAT_NEW_BIT] = r_new;
        w_rd_word[STAT_OVR_BIT] = r_ovr;
      end
      OFF_COUNT:  w_rd_word = r_cnt;
      default:    w_rd_word = '0;
    endcase
  end

  // A capture always wins over a same-cycle clear of new_flag or overrun.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      r_data <= '0;
      r_new  <= 1'b0;
      r_ovr  <= 1'b0;
      r_cnt  <= '0;
      r_dbus <= '0;
    end else begin
      if (user_data_valid) begin
        r_data <= user_data_in;
        r_new  <= 1'b1;
        r_cnt  <= r_cnt + 32'd1;
      end else if (w_rd_data) begin
        r_new  <= 1'b0;
      end
      if (user_data_valid && r_new && !w_rd_data) r_ovr <= 1'b1;
      else if (w_ovr_clr)                         r_ovr <= 1'b0;
      r_dbus <= w_rd ? w_rd_word : 32'd0;
    end
  end

  assign Sl_DBus    = r_dbus;
  assign Sl_xferAck = w_ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign w_unused = &{1'b0, OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:30],
                      (C_OPB_AWIDTH == 32), (C_OPB_DWIDTH == 32),
                      (C_FAMILY == "virtex5")};

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Directed bench for the fabric-to-PPC OPB register with an expected-read queue.
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] BASE = 32'h0100_0400;
  localparam logic [31:0] HIGH = 32'h0100_04FF;
  localparam logic [31:0] A_DATA   = BASE;
  localparam logic [31:0] A_STATUS = BASE + 32'd4;
  localparam logic [31:0] A_COUNT  = BASE + 32'd8;
  localparam logic [31:0] A_RSVD   = BASE + 32'd12;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst = 1'b1;
  logic [0:31] OPB_ABus = '0;
  logic [0:3]  OPB_BE = '0;
  logic [0:31] OPB_DBus = '0;
  logic        OPB_RNW = 1'b0;
  logic        OPB_select = 1'b0;
  logic        OPB_seqAddr = 1'b0;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic [31:0] user_data_in = '0;
  logic        user_data_valid = 1'b0;

  int n_err = 0;
  int n_checks = 0;
  logic [31:0] exp_q[$];

  opb_register_simulink2ppc #(
    .C_BASEADDR (BASE),
    .C_HIGHADDR (HIGH)
  ) dut (
    .OPB_Clk         (OPB_Clk),
    .OPB_Rst         (OPB_Rst),
    .OPB_ABus        (OPB_ABus),
    .OPB_BE          (OPB_BE),
    .OPB_DBus        (OPB_DBus),
    .OPB_RNW         (OPB_RNW),
    .OPB_select      (OPB_select),
    .OPB_seqAddr     (OPB_seqAddr),
    .Sl_DBus         (Sl_DBus),
    .Sl_xferAck      (Sl_xferAck),
    .Sl_errAck       (Sl_errAck),
    .Sl_retry        (Sl_retry),
    .Sl_toutSup      (Sl_toutSup),
    .user_data_in    (user_data_in),
    .user_data_valid (user_data_valid)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one select assertion for 'hold' cycles, optionally with a
  // same-cycle capture strobe; starts and ends on a falling edge.
  task automatic do_xfer(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int hold, input logic vld,
                         input logic [31:0] vdata, output int acks, output logic [31:0] rdata,
                         output int lat, output int bad);
    acks = 0; rdata = '0; lat = -1; bad = 0;
    OPB_select = 1'b1; OPB_ABus = addr; OPB_RNW = rnw; OPB_DBus = wdata; OPB_BE = be;
    user_data_valid = vld; user_data_in = vdata;
    for (int c = 1; c <= hold; c++) begin
      @(negedge OPB_Clk);
      user_data_valid = 1'b0;
      if (Sl_xferAck) begin
        acks++;
        rdata = Sl_DBus;
        if (lat < 0) lat = c;
      end else if (Sl_DBus !== 32'd0) begin
        bad++;
      end
    end
    OPB_select = 1'b0; OPB_ABus = '0; OPB_RNW = 1'b0; OPB_DBus = '0; OPB_BE = '0;
    @(negedge OPB_Clk);
  endtask

  task automatic opb_read(input logic [31:0] addr, input logic [31:0] exp, input string tag,
                          input int hold, input logic vld, input logic [31:0] vdata);
    int acks, lat, bad;
    logic [31:0] rdata;
    exp_q.push_back(exp);
    do_xfer(1'b1, addr, 32'd0, 4'b0000, hold, vld, vdata, acks, rdata, lat, bad);
    check({tag, "_acks"}, acks, 32'd1);
    check({tag, "_idle_dbus"}, bad, 32'd0);
    if (acks > 0) check(tag, rdata, exp_q.pop_front());
    else void'(exp_q.pop_front());
  endtask

  task automatic opb_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                           input string tag, input logic vld, input logic [31:0] vdata);
    int acks, lat, bad;
    logic [31:0] rdata;
    do_xfer(1'b0, addr, wdata, be, 2, vld, vdata, acks, rdata, lat, bad);
    check({tag, "_acks"}, acks, 32'd1);
    check({tag, "_dbus"}, rdata | bad, 32'd0);
  endtask

  task automatic pulse_valid(input logic [31:0] d);
    user_data_valid = 1'b1; user_data_in = d;
    @(negedge OPB_Clk);
    user_data_valid = 1'b0;
  endtask

  initial begin
    int acks, lat, bad;
    logic [31:0] rdata;

    // Power-on reset
    repeat (2) @(negedge OPB_Clk);
    check("rst_ack", Sl_xferAck, 1'b0);
    check("rst_dbus", Sl_DBus, 32'd0);
    check("const_outs", {Sl_errAck, Sl_retry, Sl_toutSup}, 3'b000);
    OPB_Rst = 1'b0;
    @(negedge OPB_Clk);

    // Reset in the middle of an acknowledged read
    pulse_valid(32'h1234_5678);
    OPB_select = 1'b1; OPB_ABus = A_DATA; OPB_RNW = 1'b1;
    @(negedge OPB_Clk);
    check("pre_rst_ack", Sl_xferAck, 1'b1);
    OPB_Rst = 1'b1;
    #1;
    check("midrst_ack", Sl_xferAck, 1'b0);
    check("midrst_dbus", Sl_DBus, 32'd0);
    @(negedge OPB_Clk);
    OPB_select = 1'b0; OPB_ABus = '0; OPB_RNW = 1'b0;
    OPB_Rst = 1'b0;
    @(negedge OPB_Clk);
    opb_read(A_STATUS, 32'd0, "rst_status", 2, 1'b0, 32'd0);
    opb_read(A_COUNT,  32'd0, "rst_count",  2, 1'b0, 32'd0);

    // Capture and read, select held for 5 cycles
    pulse_valid(32'hDEAD_BEEF);
    opb_read(A_STATUS, 32'd1, "cap_status_pre", 2, 1'b0, 32'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    do_xfer(1'b1, A_DATA, 32'd0, 4'b0000, 5, 1'b0, 32'd0, acks, rdata, lat, bad);
    check("hold5_acks", acks, 32'd1);
    check("hold5_latency", lat, 32'd1);
    check("hold5_idle_dbus", bad, 32'd0);
    check("cap_data", rdata, exp_q.pop_front());
    opb_read(A_STATUS, 32'd0, "cap_status_post", 2, 1'b0, 32'd0);
    opb_read(A_COUNT,  32'd1, "cap_count",       2, 1'b0, 32'd0);

    // Overrun: two captures without an intervening read
    pulse_valid(32'h1);
    pulse_valid(32'h2);
    opb_read(A_STATUS, 32'h3, "ovr_status",      2, 1'b0, 32'd0);
    opb_read(A_DATA,   32'h2, "ovr_data",        2, 1'b0, 32'd0);
    opb_read(A_STATUS, 32'h2, "ovr_sticky",      2, 1'b0, 32'd0);
    opb_write(A_STATUS, 32'h1, 4'b0001, "ovr_clr_wr", 1'b0, 32'd0);
    opb_read(A_STATUS, 32'h0, "ovr_cleared",     2, 1'b0, 32'd0);

    // DATA read coinciding with a capture returns the old word
    opb_read(A_DATA,   32'h2,         "coll_old_data", 2, 1'b1, 32'hA5A5_A5A5);
    opb_read(A_STATUS, 32'h1,         "coll_status",   2, 1'b0, 32'd0);
    opb_read(A_DATA,   32'hA5A5_A5A5, "coll_new_data", 2, 1'b0, 32'd0);

    // Overrun-clear write coinciding with an overrunning capture: set wins
    pulse_valid(32'h0000_0011);
    opb_write(A_STATUS, 32'h1, 4'b0001, "clr_coll_wr", 1'b1, 32'h0000_0022);
    opb_read(A_STATUS, 32'h3,         "clr_coll_status", 2, 1'b0, 32'd0);
    opb_read(A_DATA,   32'h0000_0022, "clr_coll_data",   2, 1'b0, 32'd0);
    opb_read(A_COUNT,  32'd6,         "count_six",       2, 1'b0, 32'd0);

    // Decode boundaries
    do_xfer(1'b1, HIGH + 32'd4, 32'd0, 4'b0000, 3, 1'b0, 32'd0, acks, rdata, lat, bad);
    check("miss_high_acks", acks, 32'd0);
    check("miss_high_dbus", bad, 32'd0);
    do_xfer(1'b1, BASE - 32'd4, 32'd0, 4'b0000, 3, 1'b0, 32'd0, acks, rdata, lat, bad);
    check("miss_low_acks", acks, 32'd0);
    check("miss_low_dbus", bad, 32'd0);
    opb_read(A_RSVD, 32'd0, "rsvd_read", 2, 1'b0, 32'd0);
    opb_read(HIGH - 32'd3, 32'd0, "high_word_read", 2, 1'b0, 32'd0);
    opb_write(A_DATA, 32'h1234_5678, 4'b1111, "data_wr", 1'b0, 32'd0);
    opb_read(A_DATA, 32'h0000_0022, "data_wr_ignored", 2, 1'b0, 32'd0);

    // Counter wrap with a preloaded count
    opb_write(A_STATUS, 32'h1, 4'b0001, "wrap_prep_clr", 1'b0, 32'd0);
    force dut.r_cnt = 32'hFFFF_FFFF;
    @(negedge OPB_Clk);
    release dut.r_cnt;
    @(negedge OPB_Clk);
    pulse_valid(32'h0BAD_F00D);
    opb_read(A_COUNT,  32'd0, "wrap_count",  2, 1'b0, 32'd0);
    opb_read(A_STATUS, 32'd1, "wrap_status", 2, 1'b0, 32'd0);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
